msg_stream_tx: RTL and testbench

Parametrised message sequencer feeding the UART transmitter. Streams a loadable buffer of up to MAX_LEN bytes as one message over a valid/ready byte handshake. Repeats the message after a programmable idle gap while enabled. Sits between the switch/control logic and the existing UART transmit block.

---
 rtl/msg_stream_pkg.sv | 25 ++
 rtl/msg_buffer.sv | 27 ++
 rtl/msg_stream_tx.sv | 186 ++++++++++++++++++
 tb/tb_msg_stream_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_stream_pkg.sv
// Shared types and constants for the message stream transmitter.
package msg_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Width of a down-counter that holds values 0 .. cycles-1 (never narrower than one bit).
    function automatic int gap_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/msg_buffer.sv
// Message byte store: MAX_LEN x 8 registers, synchronous write, combinational read.
module msg_buffer
    import msg_stream_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_r [MAX_LEN];

    // Write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/msg_stream_tx.sv
// Streams a loaded byte buffer as a repeating message over a valid/ready handshake.
// Define MSG_CRLF_EN to append CR LF after the buffer bytes of every message.
module msg_stream_tx
    import msg_stream_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int GAP_CYCLES = 15000,
    parameter int ADDR_W     = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              msg_done
);

    localparam int                GCW      = gap_cnt_w(GAP_CYCLES);
    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(MAX_LEN);
    localparam logic [GCW-1:0]    GAP_LOAD = GCW'(GAP_CYCLES - 1);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] index_r, index_s;
    logic [ADDR_W:0]   len_r, len_s;
    logic [GCW-1:0]    gap_r, gap_s;
    logic              tx_valid_r, tx_valid_s;
    logic [7:0]        tx_data_r, tx_data_s;
    logic              busy_r, busy_s;
    logic              msg_done_r, msg_done_s;
`ifdef MSG_CRLF_EN
    logic [1:0]        tail_r, tail_s;
`endif

    logic              start_ok_s;
    logic              start_s;
    logic              xfer_s;
    logic              last_s;
    logic [ADDR_W:0]   clamp_len_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [7:0]        rd_data_s;

    msg_buffer #(
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (load_we && (state_r == IDLE)),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    assign start_ok_s  = en && (msg_len != {(ADDR_W+1){1'b0}});
    assign clamp_len_s = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
    assign xfer_s      = tx_valid_r && tx_ready;
    assign last_s      = ({1'b0, index_r} == (len_r - {{ADDR_W{1'b0}}, 1'b1}));
    // In SEND the read port pre-fetches the byte that follows the one on tx_data.
    assign rd_addr_s   = (state_r == SEND) ? (index_r + {{(ADDR_W-1){1'b0}}, 1'b1})
                                           : {ADDR_W{1'b0}};

    // Next-state and output decode.
    always_comb begin
        state_s    = state_r;
        index_s    = index_r;
        len_s      = len_r;
        gap_s      = gap_r;
        tx_valid_s = tx_valid_r;
        tx_data_s  = tx_data_r;
        msg_done_s = 1'b0;
        start_s    = 1'b0;
`ifdef MSG_CRLF_EN
        tail_s     = tail_r;
`endif
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    start_s = 1'b1;
                end else begin
                    tx_valid_s = 1'b0;
                end
            end
            SEND: begin
                if (xfer_s) begin
`ifdef MSG_CRLF_EN
                    if ((tail_r == 2'd0) && !last_s) begin
                        index_s   = index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        tx_data_s = rd_data_s;
                    end else if (tail_r == 2'd0) begin
                        tail_s    = 2'd1;
                        tx_data_s = CHAR_CR;
                    end else if (tail_r == 2'd1) begin
                        tail_s    = 2'd2;
                        tx_data_s = CHAR_LF;
                    end else begin
                        tail_s     = 2'd0;
                        state_s    = GAP;
                        gap_s      = GAP_LOAD;
                        tx_valid_s = 1'b0;
                        msg_done_s = 1'b1;
                    end
`else
                    if (!last_s) begin
                        index_s   = index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        tx_data_s = rd_data_s;
                    end else begin
                        state_s    = GAP;
                        gap_s      = GAP_LOAD;
                        tx_valid_s = 1'b0;
                        msg_done_s = 1'b1;
                    end
`endif
                end else begin
                    tx_data_s = tx_data_r;
                end
            end
            GAP: begin
                if (gap_r != {GCW{1'b0}}) begin
                    gap_s = gap_r - {{(GCW-1){1'b0}}, 1'b1};
                end else if (start_ok_s) begin
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s    = IDLE;
                tx_valid_s = 1'b0;
            end
        endcase

        // A start launches buf[0] on the same edge, from IDLE or straight out of GAP.
        if (start_s) begin
            state_s    = SEND;
            len_s      = clamp_len_s;
            index_s    = {ADDR_W{1'b0}};
            tx_valid_s = 1'b1;
            tx_data_s  = rd_data_s;
        end else begin
            len_s = len_s;
        end

        busy_s = (state_s != IDLE);
    end

    // State and registered outputs; rst drops any in-flight byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            index_r    <= {ADDR_W{1'b0}};
            len_r      <= {(ADDR_W+1){1'b0}};
            gap_r      <= {GCW{1'b0}};
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            msg_done_r <= 1'b0;
`ifdef MSG_CRLF_EN
            tail_r     <= 2'd0;
`endif
        end else begin
            state_r    <= state_s;
            index_r    <= index_s;
            len_r      <= len_s;
            gap_r      <= gap_s;
            tx_valid_r <= tx_valid_s;
            tx_data_r  <= tx_data_s;
            busy_r     <= busy_s;
            msg_done_r <= msg_done_s;
`ifdef MSG_CRLF_EN
            tail_r     <= tail_s;
`endif
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;
    assign msg_done = msg_done_r;

endmodule

// File: tb/tb_msg_stream_tx.sv
// Scoreboard bench for msg_stream_tx: stimulus pushes expected bytes, a monitor pops them per transfer.
module tb_msg_stream_tx;

    localparam int MAX_LEN    = 16;
    localparam int GAP_CYCLES = 15000;
    localparam int ADDR_W     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [ADDR_W:0]   msg_len;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              tx_ready = 1'b1;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              busy;
    logic              msg_done;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] model [MAX_LEN];
    bit         rdy_mode = 1'b0;
    int         cyc = 0;

    always #5 clk = ~clk;

    msg_stream_tx #(
        .MAX_LEN    (MAX_LEN),
        .GAP_CYCLES (GAP_CYCLES),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .msg_len   (msg_len),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .busy      (busy),
        .msg_done  (msg_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_len(input int n);
`ifdef MSG_CRLF_EN
        return n + 2;
`else
        return n;
`endif
    endfunction

    // Ready driver: always 1, or low on every third cycle in stall mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tx_ready = rdy_mode ? ((cyc % 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops expectations on transfers, checks stall stability and msg_done.
    initial begin
        logic       prev_stall;
        logic       prev_done;
        logic [7:0] prev_data;
        logic [7:0] exp_b;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", tx_valid, 1);
                    chk("stall_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    if (sb.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", tx_data);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("byte", tx_data, exp_b);
                    end
                end
                if (msg_done) begin
                    chk("done_width", prev_done, 0);
                    chk("done_after_last", sb.size(), 0);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_done  = msg_done;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input int a, input logic [7:0] d);
        load_we   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = d;
        model[a]  = d;
        step();
        load_we   = 1'b0;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            load_byte(i, s[i]);
        end
    endtask

    task automatic push_msg(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(model[i]);
        end
`ifdef MSG_CRLF_EN
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
`endif
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!msg_done && n < budget);
        chk(name, msg_done, 1);
    endtask

    // Counts cycles from the msg_done cycle until tx_valid rises (or busy falls).
    task automatic count_gap(input string name, input bit use_busy);
        int n = 1;
        chk({name, "_valid_low"}, tx_valid, 0);
        forever begin
            @(negedge clk);
            if (use_busy ? !busy : tx_valid) break;
            n++;
            if (n > GAP_CYCLES + 100) break;
        end
        chk(name, n, GAP_CYCLES);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", err_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        en        = 1'b0;
        msg_len   = '0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = 8'h00;
        step();
        step();
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", msg_done, 0);
        rst = 1'b0;

        // Full message, exact gap, automatic repeat.
        load_str("hello world!");
        msg_len = 5'd12;
        push_msg(12);
        en = 1'b1;
        step();
        chk("start_latency", tx_valid, 1);
        chk("first_byte", tx_data, 8'h68);
        chk("busy_send", busy, 1);
        wait_drain("msg1_drain", 100);
        wait_done("msg1_done", 10);
        push_msg(12);
        count_gap("gap_len", 1'b0);

        // en dropped after byte 3 of the repeat; load_we while busy must be ignored.
        n = 0;
        while (sb.size() > exp_len(12) - 3 && n < 100) begin
            step();
            n++;
        end
        en        = 1'b0;
        load_we   = 1'b1;
        load_addr = '0;
        load_data = 8'hFF;
        step();
        load_we   = 1'b0;
        wait_drain("msg2_drain", 100);
        wait_done("msg2_done", 10);
        count_gap("gap_to_idle", 1'b1);
        repeat (20) step();
        chk("idle_valid", tx_valid, 0);
        chk("idle_busy", busy, 0);

        // Backpressure; also proves buf[0] is still 'h'.
        rdy_mode = 1'b1;
        push_msg(12);
        en = 1'b1;
        wait_drain("stall_drain", 200);
        wait_done("stall_done", 10);
        en       = 1'b0;
        rdy_mode = 1'b0;
        pulse_rst();

        // Zero length never starts.
        msg_len = 5'd0;
        en      = 1'b1;
        repeat (20) step();
        chk("zero_len_valid", tx_valid, 0);
        chk("zero_len_busy", busy, 0);
        en = 1'b0;

        // Over-length clamps to MAX_LEN.
        for (int i = 0; i < MAX_LEN; i++) begin
            load_byte(i, 8'hA0 + 8'(i));
        end
        msg_len = 5'd20;
        push_msg(MAX_LEN);
        en = 1'b1;
        wait_drain("clamp_drain", 100);
        wait_done("clamp_done", 10);
        chk("clamp_no_extra", tx_valid, 0);
        en = 1'b0;
        pulse_rst();

        // Reset during SEND with byte 5 in flight, then restart from buf[0].
        load_str("hello world!");
        msg_len = 5'd12;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(model[i]);
        end
        en = 1'b1;
        wait_drain("pre_rst_drain", 100);
        chk("inflight_valid", tx_valid, 1);
        chk("inflight_data", tx_data, 8'h20);
        rst = 1'b1;
        en  = 1'b0;
        step();
        chk("midrst_valid", tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", tx_data, 0);
        rst = 1'b0;
        push_msg(12);
        en = 1'b1;
        wait_drain("restart_drain", 100);
        wait_done("restart_done", 10);
        en = 1'b0;
        pulse_rst();

        // Single-byte message (CR LF follow when that option is built in).
        load_str("P");
        msg_len = 5'd1;
        push_msg(1);
        en = 1'b1;
        wait_drain("single_drain", 100);
        wait_done("single_done", 10);
        en = 1'b0;
        pulse_rst();

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
